// File: rtl/io_bank_pkg.sv
// io_bank_pkg: shared definitions for the IO bank controller.
//   - Default bank geometry (pins per bank, bank-select width).
//   - Command opcodes carried on cmd_op.
//   - Controller FSM state encoding.
package io_bank_pkg;

  localparam int unsigned IO_UNIT_NBIT = 16;
  localparam int unsigned IO_BANK_NBIT = 2;

  localparam logic [1:0] OP_WR_DB   = 2'd0;
  localparam logic [1:0] OP_WR_DIR  = 2'd1;
  localparam logic [1:0] OP_RD      = 2'd2;
  localparam logic [1:0] OP_CLR_CHG = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StRdRsp  = 2'd2
  } io_state_e;

endpackage

// File: rtl/io_pin_sync.sv
// io_pin_sync: input conditioning for one IO bank.
//   Two-flop synchroniser per pin, optional glitch filter, then an edge-detect register.
//   Optional feature macro: IO_GLITCH_FILT_EN (adds a FILT_CYC stable-sample filter).
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   din   in   raw asynchronous pad inputs (WIDTH)
//   cond  out  conditioned (synchronised, optionally filtered) pin values
//   chg   out  per-bit pulse, high for one cycle when cond changes
module io_pin_sync
  import io_bank_pkg::*;
#(
  parameter int unsigned WIDTH = IO_UNIT_NBIT
`ifdef IO_GLITCH_FILT_EN
  ,
  parameter int unsigned FILT_CYC = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cond,
  output logic [WIDTH-1:0] chg
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_GLITCH_FILT_EN
  // Counter only has to reach FILT_CYC-1.
  localparam int unsigned CntW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILT_CYC - 1);

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // Counts consecutive samples that disagree with the filtered value; any
  // agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntLast) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign cond = filt_q;
`else
  assign cond = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= cond;
    end
  end

  assign chg = cond ^ prev_q;

endmodule

// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl: parametrised controller for NBANK IO banks of UNIT_NBIT pins.
//   Masked writes to per-bank direction/output registers, conditioned inputs with sticky
//   per-pin change flags, a registered irq, and a fixed-latency read response.
//   Tristate buffers live in the top level; this block only supplies io_dir / io_dout.
//   Optional feature macro: IO_GLITCH_FILT_EN (input glitch filter, parameter FILT_CYC).
//   BANK_NBIT must satisfy 2**BANK_NBIT >= NBANK.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   cmd_vd / cmd_rdy  command handshake; accept = cmd_vd & cmd_rdy (ready only when idle)
//   cmd_op            0 WR_DB, 1 WR_DIR, 2 RD, 3 CLR_CHG
//   cmd_bank          target bank
//   cmd_mask          per-bit write enable, or clear mask for CLR_CHG
//   cmd_data          write data
//   rsp_vd            one-cycle read response strobe
//   rsp_data/rsp_chg  pin values and sticky change flags of the bank read
//   irq               OR of all sticky change flags (registered)
//   io_dir / io_dout  direction (1 = output) and output data, bank b at [b*UNIT_NBIT +: UNIT_NBIT]
//   io_din            raw asynchronous pad inputs, same packing
module io_bank_ctrl
  import io_bank_pkg::*;
#(
  parameter int unsigned NBANK     = 4,
  parameter int unsigned UNIT_NBIT = IO_UNIT_NBIT,
  parameter int unsigned BANK_NBIT = IO_BANK_NBIT,
  parameter bit          RST_DIR   = 1'b0,
  parameter bit          RST_DB    = 1'b0
`ifdef IO_GLITCH_FILT_EN
  ,
  parameter int unsigned FILT_CYC  = 4
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_vd,
  output logic                       cmd_rdy,
  input  logic [1:0]                 cmd_op,
  input  logic [BANK_NBIT-1:0]       cmd_bank,
  input  logic [UNIT_NBIT-1:0]       cmd_mask,
  input  logic [UNIT_NBIT-1:0]       cmd_data,
  output logic                       rsp_vd,
  output logic [UNIT_NBIT-1:0]       rsp_data,
  output logic [UNIT_NBIT-1:0]       rsp_chg,
  output logic                       irq,
  output logic [NBANK*UNIT_NBIT-1:0] io_dir,
  output logic [NBANK*UNIT_NBIT-1:0] io_dout,
  input  logic [NBANK*UNIT_NBIT-1:0] io_din
);

  typedef logic [UNIT_NBIT-1:0] unit_t;

  function automatic unit_t mask_wr(unit_t cur, unit_t mask, unit_t data);
    return (cur & ~mask) | (data & mask);
  endfunction

  unit_t dir_q  [NBANK];
  unit_t dout_q [NBANK];
  unit_t chg_q  [NBANK];
  unit_t chg_d  [NBANK];
  unit_t clr    [NBANK];
  unit_t cond   [NBANK];
  unit_t pulse  [NBANK];

  io_state_e            state_q;
  logic [BANK_NBIT-1:0] rd_bank_q;
  logic                 accept;
  logic                 bank_ok;
  logic [NBANK-1:0]     wr_hit;
  logic                 any_chg;
  unit_t                rd_data;
  unit_t                rd_chg;

  assign accept  = cmd_vd & cmd_rdy;
  assign bank_ok = 32'(cmd_bank) < NBANK;

  for (genvar b = 0; b < int'(NBANK); b++) begin : g_bank
    io_pin_sync #(
      .WIDTH    (UNIT_NBIT)
`ifdef IO_GLITCH_FILT_EN
      ,
      .FILT_CYC (FILT_CYC)
`endif
    ) u_pin_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (io_din[b*UNIT_NBIT +: UNIT_NBIT]),
      .cond (cond[b]),
      .chg  (pulse[b])
    );

    assign io_dir[b*UNIT_NBIT +: UNIT_NBIT]  = dir_q[b];
    assign io_dout[b*UNIT_NBIT +: UNIT_NBIT] = dout_q[b];
  end

  // Out-of-range banks never match, so their writes and clears fall away.
  always_comb begin
    wr_hit = '0;
    for (int b = 0; b < int'(NBANK); b++) begin
      wr_hit[b] = accept & bank_ok & (cmd_bank == BANK_NBIT'(b));
    end
  end

  // Sticky flags: set wins over clear. Read-clear happens on the capture edge
  // (RD_WAIT -> RD_RSP), after rsp_chg has taken the old flags.
  always_comb begin
    for (int b = 0; b < int'(NBANK); b++) begin
      clr[b] = '0;
      if (wr_hit[b] && (cmd_op == OP_CLR_CHG)) begin
        clr[b] = cmd_mask;
      end
      if ((state_q == StRdWait) && (rd_bank_q == BANK_NBIT'(b))) begin
        clr[b] = '1;
      end
      // Output pins never raise a flag.
      chg_d[b] = (chg_q[b] & ~clr[b]) | (pulse[b] & ~dir_q[b]);
    end
  end

  always_comb begin
    any_chg = 1'b0;
    for (int b = 0; b < int'(NBANK); b++) begin
      any_chg = any_chg | (|chg_q[b]);
    end
  end

  // Out-of-range read bank leaves both values at zero.
  always_comb begin
    rd_data = '0;
    rd_chg  = '0;
    for (int b = 0; b < int'(NBANK); b++) begin
      if (rd_bank_q == BANK_NBIT'(b)) begin
        rd_data = (dir_q[b] & dout_q[b]) | (~dir_q[b] & cond[b]);
        rd_chg  = chg_q[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < int'(NBANK); b++) begin
        dir_q[b]  <= {UNIT_NBIT{RST_DIR}};
        dout_q[b] <= {UNIT_NBIT{RST_DB}};
        chg_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < int'(NBANK); b++) begin
        if (wr_hit[b] && (cmd_op == OP_WR_DIR)) begin
          dir_q[b] <= mask_wr(dir_q[b], cmd_mask, cmd_data);
        end
        if (wr_hit[b] && (cmd_op == OP_WR_DB)) begin
          dout_q[b] <= mask_wr(dout_q[b], cmd_mask, cmd_data);
        end
        chg_q[b] <= chg_d[b];
      end
    end
  end

  // Command/response FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_rdy   <= 1'b1;
      rsp_vd    <= 1'b0;
      rsp_data  <= '0;
      rsp_chg   <= '0;
      irq       <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      irq    <= any_chg;
      rsp_vd <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept && (cmd_op == OP_RD)) begin
            state_q   <= StRdWait;
            cmd_rdy   <= 1'b0;
            rd_bank_q <= cmd_bank;
          end
        end
        StRdWait: begin
          state_q  <= StRdRsp;
          rsp_vd   <= 1'b1;
          rsp_data <= rd_data;
          rsp_chg  <= rd_chg;
        end
        StRdRsp: begin
          state_q <= StIdle;
          cmd_rdy <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          cmd_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bank_ctrl.sv
// tb_io_bank_ctrl: directed self-checking bench for io_bank_ctrl (NBANK=3 so bank 3 is
// out of range). Inputs are driven and outputs sampled on the falling clock edge.
module tb_io_bank_ctrl;
  import io_bank_pkg::*;

  localparam int unsigned NB = 3;
  localparam int unsigned UW = 16;
  localparam int unsigned BW = 2;
`ifdef IO_GLITCH_FILT_EN
  localparam int unsigned LAT = 2 + 4;
`else
  localparam int unsigned LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_vd = 1'b0;
  logic             cmd_rdy;
  logic [1:0]       cmd_op = 2'd0;
  logic [BW-1:0]    cmd_bank = '0;
  logic [UW-1:0]    cmd_mask = '0;
  logic [UW-1:0]    cmd_data = '0;
  logic             rsp_vd;
  logic [UW-1:0]    rsp_data;
  logic [UW-1:0]    rsp_chg;
  logic             irq;
  logic [NB*UW-1:0] io_dir;
  logic [NB*UW-1:0] io_dout;
  logic [NB*UW-1:0] io_din = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  io_bank_ctrl #(
    .NBANK     (NB),
    .UNIT_NBIT (UW),
    .BANK_NBIT (BW),
    .RST_DIR   (1'b0),
    .RST_DB    (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_vd   (cmd_vd),
    .cmd_rdy  (cmd_rdy),
    .cmd_op   (cmd_op),
    .cmd_bank (cmd_bank),
    .cmd_mask (cmd_mask),
    .cmd_data (cmd_data),
    .rsp_vd   (rsp_vd),
    .rsp_data (rsp_data),
    .rsp_chg  (rsp_chg),
    .irq      (irq),
    .io_dir   (io_dir),
    .io_dout  (io_dout),
    .io_din   (io_din)
  );

  // One accepted command; called and returns at a falling edge.
  task automatic do_cmd(input logic [1:0] op, input logic [BW-1:0] bank,
                        input logic [UW-1:0] mask, input logic [UW-1:0] data);
    cmd_op = op; cmd_bank = bank; cmd_mask = mask; cmd_data = data; cmd_vd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vd = 1'b0;
  endtask

  // Issues a read and reports whether cmd_rdy/rsp_vd followed the expected 2-cycle shape.
  task automatic do_read(input logic [BW-1:0] bank, output logic [UW-1:0] d,
                         output logic [UW-1:0] c, output logic timing_ok);
    cmd_op = OP_RD; cmd_bank = bank; cmd_mask = '0; cmd_data = '0; cmd_vd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vd = 1'b0;
    timing_ok = (cmd_rdy === 1'b0) && (rsp_vd === 1'b0);
    @(posedge clk);
    @(negedge clk);
    timing_ok &= (cmd_rdy === 1'b0) && (rsp_vd === 1'b1);
    d = rsp_data;
    c = rsp_chg;
    @(posedge clk);
    @(negedge clk);
    timing_ok &= (cmd_rdy === 1'b1) && (rsp_vd === 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (io_dir !== 48'h0) begin n_fail++;
      $display("FAIL reset_dir: got %h expected %h", io_dir, 48'h0); end
    n_chk++; if (io_dout !== 48'h0) begin n_fail++;
      $display("FAIL reset_dout: got %h expected %h", io_dout, 48'h0); end
    n_chk++; if (cmd_rdy !== 1'b1) begin n_fail++;
      $display("FAIL reset_rdy: got %b expected 1", cmd_rdy); end
    n_chk++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL reset_irq: got %b expected 0", irq); end
    n_chk++; if (rsp_vd !== 1'b0 || rsp_data !== 16'h0) begin n_fail++;
      $display("FAIL reset_rsp: got vd=%b data=%h expected vd=0 data=0000", rsp_vd, rsp_data); end
  endtask

  task automatic test_wr_dir;
    do_cmd(OP_WR_DIR, 2'd2, 16'h00FF, 16'hFFFF);
    n_chk++; if (io_dir[47:32] !== 16'h00FF) begin n_fail++;
      $display("FAIL wr_dir_bank2: got %h expected %h", io_dir[47:32], 16'h00FF); end
    n_chk++; if (io_dir !== 48'h00FF_0000_0000) begin n_fail++;
      $display("FAIL wr_dir_other: got %h expected %h", io_dir, 48'h00FF_0000_0000); end
  endtask

  task automatic test_back_to_back;
    do_cmd(OP_WR_DB, 2'd1, 16'hFFFF, 16'hA5A5);
    n_chk++; if (io_dout[31:16] !== 16'hA5A5) begin n_fail++;
      $display("FAIL wr_db_full: got %h expected %h", io_dout[31:16], 16'hA5A5); end
    do_cmd(OP_WR_DB, 2'd1, 16'h00F0, 16'h0000);
    n_chk++; if (io_dout[31:16] !== 16'hA505) begin n_fail++;
      $display("FAIL wr_db_masked: got %h expected %h", io_dout[31:16], 16'hA505); end
    do_cmd(OP_WR_DB, 2'd1, 16'h0000, 16'hFFFF);
    n_chk++; if (io_dout !== 48'h0000_A505_0000) begin n_fail++;
      $display("FAIL wr_db_mask0: got %h expected %h", io_dout, 48'h0000_A505_0000); end
  endtask

  task automatic test_read;
    logic [UW-1:0] d, c;
    logic ok;
    do_cmd(OP_WR_DIR, 2'd1, 16'hFFFF, 16'hFFFF);
    n_chk++; if (io_dir !== 48'h00FF_FFFF_0000) begin n_fail++;
      $display("FAIL rd_setup_dir: got %h expected %h", io_dir, 48'h00FF_FFFF_0000); end
    do_read(2'd1, d, c, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++;
      $display("FAIL rd_timing: got %b expected 1", ok); end
    n_chk++; if (d !== 16'hA505) begin n_fail++;
      $display("FAIL rd_data_out: got %h expected %h", d, 16'hA505); end
    n_chk++; if (c !== 16'h0) begin n_fail++;
      $display("FAIL rd_chg_out: got %h expected %h", c, 16'h0); end
  endtask

  task automatic test_change;
    logic [UW-1:0] d, c;
    logic ok;
    int cyc;
    io_din[3] = 1'b1;
    cyc = 0;
    for (int i = 1; i <= int'(LAT) + 4; i++) begin
      @(negedge clk);
      cyc = i;
      if (irq === 1'b1) break;
    end
    n_chk++; if (irq !== 1'b1 || cyc > int'(LAT) + 2) begin n_fail++;
      $display("FAIL chg_irq: got irq=%b after %0d cycles expected irq=1 within %0d",
               irq, cyc, LAT + 2); end
    do_read(2'd0, d, c, ok);
    n_chk++; if (c !== 16'h0008 || ok !== 1'b1) begin n_fail++;
      $display("FAIL chg_first_rd: got chg=%h ok=%b expected chg=0008 ok=1", c, ok); end
    n_chk++; if (d !== 16'h0008) begin n_fail++;
      $display("FAIL chg_in_data: got %h expected %h", d, 16'h0008); end
    do_read(2'd0, d, c, ok);
    n_chk++; if (c !== 16'h0) begin n_fail++;
      $display("FAIL chg_second_rd: got %h expected %h", c, 16'h0); end
    n_chk++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL chg_irq_clr: got %b expected 0", irq); end
  endtask

  task automatic test_set_wins;
    logic [UW-1:0] d, c;
    logic ok;
    // Falling edge on bit3 reaches the edge detector exactly as CLR_CHG is accepted.
    io_din[3] = 1'b0;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    do_cmd(OP_CLR_CHG, 2'd0, 16'h0008, 16'h0000);
    @(negedge clk);
    n_chk++; if (irq !== 1'b1) begin n_fail++;
      $display("FAIL setwin_irq: got %b expected 1", irq); end
    do_read(2'd0, d, c, ok);
    n_chk++; if (c !== 16'h0008) begin n_fail++;
      $display("FAIL setwin_flag: got %h expected %h", c, 16'h0008); end
    // Masked clear: bit5 cleared, bit6 kept.
    io_din[5] = 1'b1;
    io_din[6] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    do_cmd(OP_CLR_CHG, 2'd0, 16'h0020, 16'h0000);
    @(negedge clk);
    n_chk++; if (irq !== 1'b1) begin n_fail++;
      $display("FAIL clr_partial_irq: got %b expected 1", irq); end
    do_read(2'd0, d, c, ok);
    n_chk++; if (c !== 16'h0040) begin n_fail++;
      $display("FAIL clr_partial_flag: got %h expected %h", c, 16'h0040); end
  endtask

  task automatic test_output_pin;
    io_din[16] = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    n_chk++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL outpin_no_flag: got %b expected 0", irq); end
  endtask

  task automatic test_out_of_range;
    logic [UW-1:0] d, c;
    logic ok;
    do_cmd(OP_WR_DB, 2'd3, 16'hFFFF, 16'hFFFF);
    do_cmd(OP_WR_DIR, 2'd3, 16'hFFFF, 16'hFFFF);
    n_chk++; if (io_dir !== 48'h00FF_FFFF_0000) begin n_fail++;
      $display("FAIL oor_dir: got %h expected %h", io_dir, 48'h00FF_FFFF_0000); end
    n_chk++; if (io_dout !== 48'h0000_A505_0000) begin n_fail++;
      $display("FAIL oor_dout: got %h expected %h", io_dout, 48'h0000_A505_0000); end
    do_read(2'd1, d, c, ok);
    do_read(2'd3, d, c, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++;
      $display("FAIL oor_rd_timing: got %b expected 1", ok); end
    n_chk++; if (d !== 16'h0 || c !== 16'h0) begin n_fail++;
      $display("FAIL oor_rd_vals: got data=%h chg=%h expected 0000/0000", d, c); end
  endtask

`ifdef IO_GLITCH_FILT_EN
  task automatic test_filter;
    logic [UW-1:0] d, c;
    logic ok;
    io_din[7] = 1'b1;
    repeat (2) @(negedge clk);
    io_din[7] = 1'b0;
    repeat (12) @(negedge clk);
    n_chk++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL filt_short_irq: got %b expected 0", irq); end
    do_read(2'd0, d, c, ok);
    n_chk++; if (d !== 16'h0060 || c !== 16'h0) begin n_fail++;
      $display("FAIL filt_short_rd: got data=%h chg=%h expected 0060/0000", d, c); end
    io_din[7] = 1'b1;
    repeat (6) @(negedge clk);
    io_din[7] = 1'b0;
    repeat (14) @(negedge clk);
    n_chk++; if (irq !== 1'b1) begin n_fail++;
      $display("FAIL filt_long_irq: got %b expected 1", irq); end
    do_read(2'd0, d, c, ok);
    n_chk++; if (c !== 16'h0080) begin n_fail++;
      $display("FAIL filt_long_flag: got %h expected %h", c, 16'h0080); end
  endtask
`endif

  task automatic test_reset_rd;
    logic [UW-1:0] d, c;
    logic ok;
    logic seen;
    do_read(2'd1, d, c, ok);
    cmd_op = OP_RD; cmd_bank = 2'd1; cmd_vd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vd = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (rsp_vd !== 1'b0 || cmd_rdy !== 1'b1 || irq !== 1'b0) begin n_fail++;
      $display("FAIL rstrd_ctl: got vd=%b rdy=%b irq=%b expected 0/1/0", rsp_vd, cmd_rdy, irq); end
    n_chk++; if (rsp_data !== 16'h0 || rsp_chg !== 16'h0) begin n_fail++;
      $display("FAIL rstrd_rsp: got data=%h chg=%h expected 0000/0000", rsp_data, rsp_chg); end
    n_chk++; if (io_dir !== 48'h0 || io_dout !== 48'h0) begin n_fail++;
      $display("FAIL rstrd_regs: got dir=%h dout=%h expected 0/0", io_dir, io_dout); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_vd === 1'b1) seen = 1'b1;
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++;
      $display("FAIL rstrd_dropped: got rsp_vd seen=%b expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_wr_dir();
    test_back_to_back();
    test_read();
    test_change();
    test_set_wins();
    test_output_pin();
    test_out_of_range();
`ifdef IO_GLITCH_FILT_EN
    test_filter();
`endif
    test_reset_rd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
